booth_mac_accum: RTL and testbench

- Sequential accumulate/requantize stage directly downstream of the Booth multiplier array in the DNN datapath.
- Consumes a stream of signed 2N-bit products that make up one dot product (one neuron), framed by first/last flags.
- Accumulates the products, adds a bias, rounds, right-shifts, applies optional ReLU and saturates to an N-bit activation.
- Presents the result on a valid/ready output port to the next layer buffer.

---
 rtl/booth_mac_accum_pkg.sv | 44 ++++
 rtl/booth_mac_accum_requant_sat.sv | 26 ++
 rtl/booth_mac_accum.sv | 119 +++++++++++
 tb/tb_booth_mac_accum.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mac_accum_pkg.sv
// Shared types, default widths and the requantize/saturate helper for the MAC accumulate stage.
// Ports: none (package).
// Holds the FSM state type, parameter defaults and the sat_round() helper.
package booth_mac_accum_pkg;

  localparam int N_DEF     = 8;
  localparam int ACC_W_DEF = 32;
  localparam int SHIFT_DEF = 4;

  // Working width of sat_round(); callers sign-extend narrower sums into it.
  localparam int SAT_W = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Takes a sum that already carries bias and the rounding half-LSB.
  // Floors by 'shift', optionally clamps negatives to zero, then clamps
  // into the signed n-bit range. Result is sign-extended to SAT_W bits.
  function automatic logic signed [SAT_W-1:0] sat_round(
    input logic signed [SAT_W-1:0] t,
    input int                      shift,
    input logic                    relu,
    input int                      n
  );
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    r  = t >>> shift;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (relu && r[SAT_W-1]) begin
      r = '0;
    end
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_mac_accum_requant_sat.sv
// Combinational requantizer: bias add, round-half-up, arithmetic shift, optional ReLU, saturate to N bits.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: i_acc (ACC_W signed sum), i_bias (ACC_W signed bias), o_q (N-bit signed activation).
module booth_mac_accum_requant_sat
  import booth_mac_accum_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int SHIFT   = SHIFT_DEF,
  parameter int RELU_EN = 1
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ACC_W-1:0] i_bias,
  output logic [N-1:0]     o_q
);

  // Half an output LSB, so the floor shift below rounds to nearest.
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(64'd1 << (SHIFT - 1));

  logic signed [ACC_W-1:0] w_t;

  // Sum wraps at ACC_W bits before the shift, matching the accumulator.
  assign w_t = $signed(i_acc) + $signed(i_bias) + RND;
  assign o_q = N'(sat_round(64'(w_t), SHIFT, (RELU_EN != 0), N));

endmodule

// File: rtl/booth_mac_accum.sv
// Accumulates framed signed products into one dot product, then requantizes to an N-bit activation.
// Latency: result valid the cycle after the last beat is accepted; one beat per cycle.
// Backpressure: in_ready = ~(out_valid & ~out_ready); a held result freezes accumulation entirely.
// Ports: clk/rst_n; in_valid/in_ready/in_prod/in_first/in_last/bias (product stream);
//        out_valid/out_ready/out_data/out_terms (result); seq_err (framing error pulse).
module booth_mac_accum
  import booth_mac_accum_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int SHIFT   = SHIFT_DEF,
  parameter int RELU_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_prod,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [ACC_W-1:0] bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [15:0]      out_terms,
  output logic             seq_err
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic [15:0]             r_term_cnt;
  logic [15:0]             w_term_cnt_nxt;
  logic                    w_seq_err_nxt;
  logic                    w_accept;
  logic                    r_out_valid;
  logic [N-1:0]            r_out_data;
  logic [15:0]             r_out_terms;
  logic                    r_seq_err;
  logic [N-1:0]            w_q;

  assign in_ready   = ~(r_out_valid & ~out_ready);
  assign w_accept   = in_valid & in_ready;
  assign w_prod_ext = ACC_W'($signed(in_prod));

  // Next-state / datapath. Without an accepted beat everything holds,
  // which is also how a held output freezes the accumulator.
  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_term_cnt_nxt = r_term_cnt;
    w_seq_err_nxt  = 1'b0;
    if (w_accept) begin
      if (in_first || (r_state == ST_IDLE)) begin
        // A new frame; an open sum (if any) is abandoned.
        w_acc_nxt      = w_prod_ext;
        w_term_cnt_nxt = 16'd1;
        w_seq_err_nxt  = (in_first && (r_state == ST_ACCUM)) ||
                         (!in_first && (r_state == ST_IDLE));
      end else begin
        w_acc_nxt      = r_acc + w_prod_ext;
        w_term_cnt_nxt = (r_term_cnt == 16'hFFFF) ? r_term_cnt : r_term_cnt + 16'd1;
      end
      w_state_nxt = in_last ? ST_IDLE : ST_ACCUM;
    end
  end

  // Requantize the sum that includes this cycle's beat.
  booth_mac_accum_requant_sat #(
    .N      (N),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT),
    .RELU_EN(RELU_EN)
  ) u_requant (
    .i_acc (w_acc_nxt),
    .i_bias(bias),
    .o_q   (w_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_term_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_term_cnt <= w_term_cnt_nxt;
    end
  end

  // Output register: loading a new result takes priority over draining,
  // so a last beat arriving as the old result leaves keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_terms <= '0;
      r_seq_err   <= 1'b0;
    end else begin
      r_seq_err <= w_seq_err_nxt;
      if (w_accept && in_last) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_q;
        r_out_terms <= w_term_cnt_nxt;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_terms = r_out_terms;
  assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Testbench for booth_mac_accum: two instances (ReLU on / off) share one input stream.
// Directed scenarios plus a randomized run against a plain-arithmetic reference model.
module tb_booth_mac_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        in_first;
  logic        in_last;
  logic [31:0] bias;
  logic        out_ready;

  logic        rdy_a, rdy_b, vld_a, vld_b, err_a, err_b;
  logic [7:0]  dat_a, dat_b;
  logic [15:0] terms_a, terms_b;

  int tests = 0;
  int fails = 0;

  booth_mac_accum #(.N(8), .ACC_W(32), .SHIFT(4), .RELU_EN(1)) u_dut_relu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_prod(in_prod),
    .in_first(in_first), .in_last(in_last), .bias(bias), .out_valid(vld_a),
    .out_ready(out_ready), .out_data(dat_a), .out_terms(terms_a), .seq_err(err_a)
  );

  booth_mac_accum #(.N(8), .ACC_W(32), .SHIFT(4), .RELU_EN(0)) u_dut_norelu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_prod(in_prod),
    .in_first(in_first), .in_last(in_last), .bias(bias), .out_valid(vld_b),
    .out_ready(out_ready), .out_data(dat_b), .out_terms(terms_b), .seq_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int prod; bit first; bit last; int bias; } beat_t;
  typedef struct { int ea; int eb; int terms; } res_t;

  // Reference: floor((sum + bias + 8) / 16), optional ReLU, clamp to int8.
  function automatic int model(input longint s, input bit relu);
    longint t;
    longint r;
    t = s + 8;
    r = (t >= 0) ? (t / 16) : -((-t + 15) / 16);
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int prod, input bit first, input bit last, input int b);
    in_valid = 1'b1;
    in_prod  = prod[15:0];
    in_first = first;
    in_last  = last;
    bias     = b;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; in_prod = '0; bias = '0;
    idle();
    step(); step();
    tests++;
    if (vld_a !== 1'b0 || vld_b !== 1'b0 || dat_a !== 8'd0 || terms_a !== 16'd0 || err_a !== 1'b0 || rdy_a !== 1'b1) begin
      fails++;
      $display("FAIL reset_state got vld=%b dat=%0d terms=%0d err=%b rdy=%b want 0 0 0 0 1", vld_a, dat_a, terms_a, err_a, rdy_a);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(100, 1, 0, 0);  step();
    drive(200, 0, 0, 0);  step();
    tests++;
    if (vld_a !== 1'b0) begin fails++; $display("FAIL basic_early_valid got=%b want=0", vld_a); end
    drive(-50, 0, 1, 16); step(); idle();
    tests++;
    if (vld_a !== 1'b1 || dat_a !== 8'd17 || dat_b !== 8'd17) begin
      fails++; $display("FAIL basic_data got vld=%b a=%0d b=%0d want 1 17 17", vld_a, dat_a, dat_b);
    end
    tests++;
    if (terms_a !== 16'd3) begin fails++; $display("FAIL basic_terms got=%0d want=3", terms_a); end
    step();
    tests++;
    if (vld_a !== 1'b0) begin fails++; $display("FAIL basic_drain got vld=%b want=0", vld_a); end
  endtask

  task automatic test_saturation();
    drive(16000, 1, 0, 0); step();
    drive(16000, 0, 1, 0); step(); idle();
    tests++;
    if (dat_a !== 8'd127 || dat_b !== 8'd127 || terms_a !== 16'd2) begin
      fails++; $display("FAIL sat_pos got a=%0d b=%0d terms=%0d want 127 127 2", dat_a, dat_b, terms_a);
    end
    step();
  endtask

  task automatic test_relu();
    drive(-1000, 1, 1, 0); step(); idle();
    tests++;
    if (dat_a !== 8'd0 || dat_b !== 8'hC2 || terms_a !== 16'd1) begin
      fails++; $display("FAIL relu got relu=%h norelu=%h terms=%0d want 00 c2 1", dat_a, dat_b, terms_a);
    end
    step();
  endtask

  task automatic test_neg_sat();
    drive(-32768, 1, 1, 0); step(); idle();
    tests++;
    if (dat_b !== 8'h80 || dat_a !== 8'h00 || terms_b !== 16'd1) begin
      fails++; $display("FAIL neg_sat got norelu=%h relu=%h terms=%0d want 80 00 1", dat_b, dat_a, terms_b);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(10, 1, 0, 0); step();
    drive(20, 0, 1, 0); step();
    drive(48, 1, 0, 0);
    tests++;
    if (vld_a !== 1'b1 || dat_a !== 8'd2 || rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
      fails++; $display("FAIL bp_first got vld=%b dat=%0d rdy=%b want 1 2 0", vld_a, dat_a, rdy_a);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (vld_a !== 1'b1 || dat_a !== 8'd2 || terms_a !== 16'd2 || rdy_a !== 1'b0 || err_a !== 1'b0) begin
        fails++; $display("FAIL bp_hold got vld=%b dat=%0d terms=%0d rdy=%b err=%b want 1 2 2 0 0", vld_a, dat_a, terms_a, rdy_a, err_a);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (rdy_a !== 1'b1) begin fails++; $display("FAIL bp_release_rdy got=%b want=1", rdy_a); end
    step();
    tests++;
    if (vld_a !== 1'b0) begin fails++; $display("FAIL bp_drain got vld=%b want=0", vld_a); end
    drive(32, 0, 0, 0); step();
    drive(16, 0, 1, 0); step(); idle();
    tests++;
    if (vld_a !== 1'b1 || dat_a !== 8'd6 || terms_a !== 16'd3 || err_a !== 1'b0) begin
      fails++; $display("FAIL bp_second got vld=%b dat=%0d terms=%0d err=%b want 1 6 3 0", vld_a, dat_a, terms_a, err_a);
    end
    // New last beat accepted while the previous result drains.
    drive(160, 1, 1, 0); step(); idle();
    tests++;
    if (vld_a !== 1'b1 || dat_a !== 8'd10 || terms_a !== 16'd1) begin
      fails++; $display("FAIL bp_overlap got vld=%b dat=%0d terms=%0d want 1 10 1", vld_a, dat_a, terms_a);
    end
    step();
    tests++;
    if (vld_a !== 1'b0) begin fails++; $display("FAIL bp_final_drain got vld=%b want=0", vld_a); end
  endtask

  task automatic test_reset_framing();
    out_ready = 1'b0;
    drive(1000, 1, 0, 0); step();
    drive(600, 0, 1, 0);  step(); idle();
    tests++;
    if (vld_a !== 1'b1 || dat_a !== 8'd100 || terms_a !== 16'd2) begin
      fails++; $display("FAIL frm_held got vld=%b dat=%0d terms=%0d want 1 100 2", vld_a, dat_a, terms_a);
    end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (vld_a !== 1'b0 || dat_a !== 8'd0 || terms_a !== 16'd0 || err_a !== 1'b0 || rdy_a !== 1'b1) begin
      fails++; $display("FAIL frm_async_reset got vld=%b dat=%0d terms=%0d err=%b rdy=%b want 0 0 0 0 1", vld_a, dat_a, terms_a, err_a, rdy_a);
    end
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    // Leave a partial sum open, then reset it away.
    drive(3000, 1, 0, 0); step(); idle();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    drive(320, 0, 1, 0); step(); idle();
    tests++;
    if (err_a !== 1'b1 || vld_a !== 1'b1 || dat_a !== 8'd20 || terms_a !== 16'd1) begin
      fails++; $display("FAIL frm_nofirst got err=%b vld=%b dat=%0d terms=%0d want 1 1 20 1", err_a, vld_a, dat_a, terms_a);
    end
    drive(5, 1, 0, 0); step();
    tests++;
    if (err_a !== 1'b0) begin fails++; $display("FAIL frm_err_pulse got=%b want=0", err_a); end
    drive(7, 0, 1, 0); step(); idle();
    tests++;
    if (dat_a !== 8'd1 || terms_a !== 16'd2 || err_a !== 1'b0) begin
      fails++; $display("FAIL frm_5_7 got dat=%0d terms=%0d err=%b want 1 2 0", dat_a, terms_a, err_a);
    end
    drive(40, 1, 0, 0); step();
    drive(64, 1, 1, 0); step(); idle();
    tests++;
    if (err_a !== 1'b1 || err_b !== 1'b1 || dat_a !== 8'd4 || terms_a !== 16'd1) begin
      fails++; $display("FAIL frm_restart got err=%b dat=%0d terms=%0d want 1 4 1", err_a, dat_a, terms_a);
    end
    step();
  endtask

  task automatic test_random();
    beat_t beats[$];
    res_t  exp_q[$];
    int    bi = 0;
    int    cyc = 0;
    bit    prev_acc = 0;
    bit    hold = 0;
    logic [7:0]  hd_a = '0, hd_b = '0;
    logic [15:0] ht = '0;
    for (int v = 0; v < 40; v++) begin
      int     len = $urandom_range(1, 6);
      longint s = 0;
      beat_t  b;
      res_t   r;
      for (int k = 0; k < len; k++) begin
        b.prod  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4000)) - 2000
                                              : int'($urandom_range(0, 65535)) - 32768;
        b.first = (k == 0);
        b.last  = (k == len - 1);
        b.bias  = int'($urandom_range(0, 8000)) - 4000;
        s += b.prod;
        if (b.last) s += b.bias;
        beats.push_back(b);
      end
      r.ea = model(s, 1'b1);
      r.eb = model(s, 1'b0);
      r.terms = len;
      exp_q.push_back(r);
    end
    idle();
    while ((bi < beats.size() || exp_q.size() != 0) && cyc < 4000) begin
      if (prev_acc) begin bi++; in_valid = 1'b0; end
      if (bi < beats.size()) begin
        int p;
        p = beats[bi].prod;
        if (!in_valid) in_valid = ($urandom_range(0, 3) != 0);
        in_prod  = p[15:0];
        in_first = beats[bi].first;
        in_last  = beats[bi].last;
        bias     = beats[bi].bias;
      end else begin
        idle();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (hold) begin
        tests++;
        if (vld_a !== 1'b1 || dat_a !== hd_a || dat_b !== hd_b || terms_a !== ht) begin
          fails++; $display("FAIL rnd_stable got vld=%b dat=%0d terms=%0d want 1 %0d %0d", vld_a, dat_a, terms_a, hd_a, ht);
        end
      end
      if (vld_a === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rnd_spurious got out_valid=1 want no pending result");
        end else if (out_ready) begin
          tests++;
          if ($signed(dat_a) != exp_q[0].ea || $signed(dat_b) != exp_q[0].eb || int'(terms_a) != exp_q[0].terms) begin
            fails++;
            $display("FAIL rnd_result got a=%0d b=%0d terms=%0d want %0d %0d %0d",
                     $signed(dat_a), $signed(dat_b), terms_a, exp_q[0].ea, exp_q[0].eb, exp_q[0].terms);
          end
          void'(exp_q.pop_front());
        end
      end
      hold = (vld_a === 1'b1) && !out_ready;
      hd_a = dat_a; hd_b = dat_b; ht = terms_a;
      prev_acc = in_valid && (rdy_a === 1'b1);
      step();
      cyc++;
    end
    idle();
    out_ready = 1'b1;
    tests++;
    if (exp_q.size() != 0 || bi < beats.size()) begin
      fails++; $display("FAIL rnd_timeout got pending=%0d beats_left=%0d want 0 0", exp_q.size(), beats.size() - bi);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_relu();
    test_neg_sat();
    test_backpressure();
    test_reset_framing();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
